// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: pseudo-random mole spawning, hit scoring, pause handling
// and the 1 s tick / restart controls for the external game timer.
module whack_game_ctrl #(
  parameter int unsigned TICK_DIV       = 100_000_000,
  parameter int unsigned MOLE_UP_CYCLES = 75_000_000,
  parameter int unsigned GAP_CYCLES     = 25_000_000,
  parameter int unsigned NUM_HOLES      = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_btn,
  input  logic                 pause_btn,
  input  logic [NUM_HOLES-1:0] hit_btn,
  input  logic                 timer_done,
  output logic                 sec_tick,
  output logic                 pause,
  output logic                 timer_rst,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic [3:0]           score,
  output logic                 game_over
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int UW = $clog2(MOLE_UP_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, PAUSED, OVER} state_t;

  state_t               state;
  state_t               saved_state;
  logic [15:0]          lfsr;
  logic [PW-1:0]        presc;
  logic [UW-1:0]        up_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [3:0]           prev_hole;
  logic [NUM_HOLES-1:0] held_mask;
  logic                 guard;

  logic                 in_play;
  logic                 done_seen;
  logic                 hit_match;
  logic [3:0]           raw_hole;
  logic [3:0]           next_hole;
  logic [NUM_HOLES-1:0] spawn_mask;

  // A stale timer_done from the previous game is masked while the timer reloads.
  always_comb begin
    in_play    = (state == SPAWN) || (state == UP) || (state == GAP);
    done_seen  = timer_done && !timer_rst && !guard && (in_play || (state == PAUSED));
    hit_match  = |(hit_btn & mole_mask);
    raw_hole   = {1'b0, lfsr[2:0]} % 4'(NUM_HOLES);
    next_hole  = raw_hole;
    if (raw_hole == prev_hole)
      next_hole = (raw_hole + 4'd1) % 4'(NUM_HOLES);
    spawn_mask = NUM_HOLES'(1) << next_hole;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      saved_state <= IDLE;
      lfsr        <= LFSR_SEED;
      presc       <= '0;
      up_cnt      <= '0;
      gap_cnt     <= '0;
      prev_hole   <= '0;
      held_mask   <= '0;
      guard       <= 1'b0;
      sec_tick    <= 1'b0;
      pause       <= 1'b0;
      timer_rst   <= 1'b0;
      mole_mask   <= '0;
      score       <= '0;
      game_over   <= 1'b0;
    end else begin
      if (state != PAUSED)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sec_tick  <= 1'b0;
      timer_rst <= 1'b0;
      guard     <= timer_rst;

      // The pause-press cycle is treated as frozen so no tick can land inside PAUSED.
      if (in_play && !done_seen && !pause_btn) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc    <= '0;
          sec_tick <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      if (done_seen) begin
        state     <= OVER;
        game_over <= 1'b1;
        pause     <= 1'b0;
        mole_mask <= '0;
      end else if (pause_btn && in_play) begin
        saved_state <= state;
        held_mask   <= mole_mask;
        mole_mask   <= '0;
        pause       <= 1'b1;
        state       <= PAUSED;
      end else begin
        unique case (state)
          IDLE, OVER: begin
            if (start_btn) begin
              state     <= SPAWN;
              score     <= '0;
              presc     <= '0;
              timer_rst <= 1'b1;
              game_over <= 1'b0;
            end
          end
          SPAWN: begin
            mole_mask <= spawn_mask;
            prev_hole <= next_hole;
            up_cnt    <= UW'(MOLE_UP_CYCLES - 1);
            state     <= UP;
          end
          UP: begin
            if (hit_match) begin
              if (score != 4'd15)
                score <= score + 4'd1;
              mole_mask <= '0;
              gap_cnt   <= GW'(GAP_CYCLES - 1);
              state     <= GAP;
            end else if (up_cnt == '0) begin
              mole_mask <= '0;
              gap_cnt   <= GW'(GAP_CYCLES - 1);
              state     <= GAP;
            end else begin
              up_cnt <= up_cnt - 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == '0)
              state <= SPAWN;
            else
              gap_cnt <= gap_cnt - 1'b1;
          end
          PAUSED: begin
            if (pause_btn) begin
              state     <= saved_state;
              mole_mask <= held_mask;
              pause     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Randomized bench for whack_game_ctrl, compared every cycle against a behavioural
// model that tracks the game as flags plus remaining-cycle budgets.
module tb_whack_game_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_btn = 1'b0;
  logic         pause_btn = 1'b0;
  logic         timer_done = 1'b0;
  logic [N-1:0] hit_btn = '0;
  logic         sec_tick, pause, timer_rst, game_over;
  logic [N-1:0] mole_mask;
  logic [3:0]   score;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the game, expressed as "running / paused / over" flags and cycle budgets.
  logic [15:0]  m_lfsr = 16'hACE1;
  bit           m_running = 0, m_paused = 0, m_over = 0;
  int           m_hole = -1, m_prev = 0, m_vis = 0, m_gap = 0;
  int           m_play = 0, m_since = 100, m_score = 0;
  bit           e_tick = 0, e_trst = 0, m_spawned = 0;
  bit           have_spawn = 0;
  logic [N-1:0] last_spawn = '0;

  whack_game_ctrl #(
    .TICK_DIV(10), .MOLE_UP_CYCLES(6), .GAP_CYCLES(3), .NUM_HOLES(N), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .hit_btn(hit_btn), .timer_done(timer_done), .sec_tick(sec_tick), .pause(pause),
    .timer_rst(timer_rst), .mole_mask(mole_mask), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [N-1:0] exp_mask();
    if (m_running && !m_paused && m_hole >= 0)
      return N'(1) << m_hole;
    return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit st, input bit pb,
                           input logic [N-1:0] hit, input bit done);
    logic [15:0] cur;
    bit ign;
    int h;
    e_tick = 0;
    e_trst = 0;
    m_spawned = 0;
    if (r) begin
      m_lfsr = 16'hACE1; m_running = 0; m_paused = 0; m_over = 0;
      m_hole = -1; m_prev = 0; m_vis = 0; m_gap = 0; m_play = 0;
      m_since = 100; m_score = 0;
      return;
    end
    cur = m_lfsr;
    if (!m_paused) m_lfsr = lfsr_next(m_lfsr);
    ign = (m_since < 2);
    if (m_since < 100) m_since++;
    if (m_running && done && !ign) begin
      m_running = 0; m_paused = 0; m_over = 1; m_hole = -1;
    end else if (m_running && pb) begin
      m_paused = !m_paused;
    end else if (m_running && !m_paused) begin
      m_play++;
      if (m_play % 10 == 0) e_tick = 1;
      if (m_hole < 0 && m_gap == 0) begin
        h = int'(cur[2:0]) % N;
        if (h == m_prev) h = (h + 1) % N;
        m_hole = h; m_prev = h; m_vis = 6; m_spawned = 1;
      end else if (m_hole >= 0) begin
        if (hit[m_hole]) begin
          if (m_score < 15) m_score++;
          m_hole = -1; m_gap = 3;
        end else begin
          m_vis--;
          if (m_vis == 0) begin m_hole = -1; m_gap = 3; end
        end
      end else begin
        m_gap--;
      end
    end else if (!m_running && st) begin
      m_running = 1; m_over = 0; m_score = 0; m_play = 0; e_trst = 1;
      m_hole = -1; m_gap = 0; m_since = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit st, input bit pb,
                               input logic [N-1:0] hit, input bit done);
    @(negedge clk);
    rst = r; start_btn = st; pause_btn = pb; hit_btn = hit; timer_done = done;
    @(posedge clk);
    modelStep(r, st, pb, hit, done);
    #1;
    checkOutput("sec_tick", sec_tick, e_tick);
    checkOutput("timer_rst", timer_rst, e_trst);
    checkOutput("pause", pause, m_paused);
    checkOutput("mole_mask", mole_mask, exp_mask());
    checkOutput("score", score, m_score);
    checkOutput("game_over", game_over, m_over);
    if (m_spawned) begin
      if (have_spawn) checkOutput("adjacent_hole", mole_mask != last_spawn, 1);
      last_spawn = mole_mask;
      have_spawn = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0);
  endtask

  // Wait (bounded) for a visible mole, optionally with exactly v cycles left.
  task automatic waitVis(input int v);
    int k;
    k = 0;
    while (!(m_running && !m_paused && m_hole >= 0 && (v == 0 || m_vis == v)) && k < 40) begin
      applyStimulus(0, 0, 0, '0, 0);
      k++;
    end
    if (k >= 40) checkOutput("wait_bound", 0, 1);
  endtask

  initial begin
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    idle($urandom_range(3, 12));
    applyStimulus(0, 1, 0, '0, 0);
    idle(30);

    waitVis(0);
    applyStimulus(0, 0, 0, N'(1) << m_hole, 0);
    waitVis(0);
    applyStimulus(0, 0, 0, N'(1) << ((m_hole + 1) % N), 0);
    waitVis(1);
    applyStimulus(0, 0, 0, N'(1) << m_hole, 0);

    idle(520);

    waitVis(2);
    applyStimulus(0, 0, 1, '0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, N'($urandom), 0);
    applyStimulus(0, 0, 1, '0, 0);
    idle(12);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(0, ($urandom % 50) == 0, ($urandom % 40) == 0,
                    (($urandom % 3) == 0) ? N'($urandom) : '0, 0);
    end
    if (m_paused) applyStimulus(0, 0, 1, '0, 0);

    for (int i = 0; i < 20 && m_score < 15; i++) begin
      waitVis(0);
      applyStimulus(0, 0, 0, N'(1) << m_hole, 0);
    end
    waitVis(0);
    applyStimulus(0, 0, 0, N'(1) << m_hole, 0);

    waitVis(0);
    applyStimulus(0, 0, 0, N'(1) << m_hole, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 1, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 0);
    idle(40);

    waitVis(0);
    applyStimulus(0, 0, 1, '0, 0);
    idle(3);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 1, 0, '0, 0);
    idle(13);
    applyStimulus(1, 0, 0, '0, 0);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
